// File: rtl/router_fsm_if.sv
// Signal bundle between the router packet-reception FSM and its neighbours
// (source, register block, synchroniser).
interface router_fsm_if;
   // pkt_valid qualifies data_in; while busy=1 the source must hold the current byte,
   // and the byte is taken on the rising edge where pkt_valid=1 and busy=0.
   logic       pkt_valid;
   logic [1:0] data_in;
   logic       fifo_full;
   logic       fifo_empty_0;
   logic       fifo_empty_1;
   logic       fifo_empty_2;
   logic       soft_reset_0;
   logic       soft_reset_1;
   logic       soft_reset_2;
   logic       parity_done;
   logic       low_pkt_valid;
   logic       busy;
   logic       detect_add;
   logic       lfd_state;
   logic       ld_state;
   logic       laf_state;
   logic       full_state;
   logic       write_enb_reg;
   logic       rst_int_reg;

   modport slave (
      input  pkt_valid, data_in, fifo_full,
      input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
      input  soft_reset_0, soft_reset_1, soft_reset_2,
      input  parity_done, low_pkt_valid,
      output busy, detect_add, lfd_state, ld_state, laf_state,
      output full_state, write_enb_reg, rst_int_reg
   );

   modport master (
      output pkt_valid, data_in, fifo_full,
      output fifo_empty_0, fifo_empty_1, fifo_empty_2,
      output soft_reset_0, soft_reset_1, soft_reset_2,
      output parity_done, low_pkt_valid,
      input  busy, detect_add, lfd_state, ld_state, laf_state,
      input  full_state, write_enb_reg, rst_int_reg
   );
endinterface

// File: rtl/router_fsm.sv
// Packet-reception controller for the 1x3 router: a Moore FSM that sequences
// header decode, payload load, parity load and FIFO-full stalls.
module router_fsm (
   input  logic             clk,
   input  logic             resetn,
   router_fsm_if.slave      bus,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      WAIT_TILL_EMPTY    = 3'd1,
      LOAD_FIRST_DATA    = 3'd2,
      LOAD_DATA          = 3'd3,
      FIFO_FULL_STATE    = 3'd4,
      LOAD_AFTER_FULL    = 3'd5,
      LOAD_PARITY        = 3'd6,
      CHECK_PARITY_ERROR = 3'd7
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] addr_q, addr_d;
   logic       empty_in;
   logic       empty_addr;
   logic       soft_addr;

   // Address 3 selects nothing: it reads as never-empty and never soft-reset.
   always_comb begin
      empty_in   = 1'b0;
      empty_addr = 1'b0;
      soft_addr  = 1'b0;
      case (bus.data_in)
         2'd0:    empty_in = bus.fifo_empty_0;
         2'd1:    empty_in = bus.fifo_empty_1;
         2'd2:    empty_in = bus.fifo_empty_2;
         default: empty_in = 1'b0;
      endcase
      case (addr_q)
         2'd0:    begin empty_addr = bus.fifo_empty_0; soft_addr = bus.soft_reset_0; end
         2'd1:    begin empty_addr = bus.fifo_empty_1; soft_addr = bus.soft_reset_1; end
         2'd2:    begin empty_addr = bus.fifo_empty_2; soft_addr = bus.soft_reset_2; end
         default: begin empty_addr = 1'b0;             soft_addr = 1'b0;             end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= DECODE_ADDRESS;
         addr_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      if (state_q == DECODE_ADDRESS && bus.pkt_valid)
         addr_d = bus.data_in;
      if (state_q != DECODE_ADDRESS && soft_addr) begin
         state_d = DECODE_ADDRESS;
      end else begin
         case (state_q)
            DECODE_ADDRESS:
               if (bus.pkt_valid && bus.data_in != 2'd3)
                  state_d = empty_in ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            WAIT_TILL_EMPTY:
               if (empty_addr) state_d = LOAD_FIRST_DATA;
            LOAD_FIRST_DATA:
               state_d = LOAD_DATA;
            LOAD_DATA:
               if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
               else if (!bus.pkt_valid) state_d = LOAD_PARITY;
            FIFO_FULL_STATE:
               if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL:
               if (bus.parity_done)        state_d = DECODE_ADDRESS;
               else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
               else                        state_d = LOAD_DATA;
            LOAD_PARITY:
               state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR:
               state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            default:
               state_d = DECODE_ADDRESS;
         endcase
      end
   end

   always_comb begin
      bus.busy          = 1'b0;
      bus.detect_add    = 1'b0;
      bus.lfd_state     = 1'b0;
      bus.ld_state      = 1'b0;
      bus.laf_state     = 1'b0;
      bus.full_state    = 1'b0;
      bus.write_enb_reg = 1'b0;
      bus.rst_int_reg   = 1'b0;
      case (state_q)
         DECODE_ADDRESS:     bus.detect_add = 1'b1;
         WAIT_TILL_EMPTY:    bus.busy = 1'b1;
         LOAD_FIRST_DATA:    begin bus.lfd_state = 1'b1; bus.busy = 1'b1; end
         LOAD_DATA:          begin bus.ld_state = 1'b1; bus.write_enb_reg = 1'b1; end
         FIFO_FULL_STATE:    begin bus.full_state = 1'b1; bus.busy = 1'b1; end
         LOAD_AFTER_FULL:    begin bus.laf_state = 1'b1; bus.write_enb_reg = 1'b1; bus.busy = 1'b1; end
         LOAD_PARITY:        begin bus.write_enb_reg = 1'b1; bus.busy = 1'b1; end
         CHECK_PARITY_ERROR: begin bus.rst_int_reg = 1'b1; bus.busy = 1'b1; end
         default:            bus.detect_add = 1'b1;
      endcase
   end

   assign dbg_state = state_q;

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: the driver pushes the expected state/output
// vector per cycle, a negedge monitor pops and compares.
module tb_router_fsm;

   logic       clk;
   logic       resetn;
   logic [2:0] dbg_state;

   router_fsm_if rif();

   router_fsm dut (
      .clk       (clk),
      .resetn    (resetn),
      .bus       (rif),
      .dbg_state (dbg_state)
   );

   localparam logic [2:0] S_DEC = 3'd0, S_WAIT = 3'd1, S_LFD = 3'd2, S_LD = 3'd3,
                          S_FULL = 3'd4, S_LAF = 3'd5, S_LP = 3'd6, S_CPE = 3'd7;

   logic [10:0] exp_q[$];
   int total;
   int bad;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs {busy,detect_add,lfd,ld,laf,full,wen,rst_int} per state.
   function automatic logic [7:0] dec(input logic [2:0] s);
      case (s)
         S_DEC:   return 8'b0100_0000;
         S_WAIT:  return 8'b1000_0000;
         S_LFD:   return 8'b1010_0000;
         S_LD:    return 8'b0001_0010;
         S_FULL:  return 8'b1000_0100;
         S_LAF:   return 8'b1000_1010;
         S_LP:    return 8'b1000_0010;
         default: return 8'b1000_0001;
      endcase
   endfunction

   task automatic cyc(input logic [2:0] st);
      exp_q.push_back({st, dec(st)});
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      rif.pkt_valid     = 1'b0;
      rif.data_in       = 2'd0;
      rif.fifo_full     = 1'b0;
      rif.fifo_empty_0  = 1'b1;
      rif.fifo_empty_1  = 1'b1;
      rif.fifo_empty_2  = 1'b1;
      rif.soft_reset_0  = 1'b0;
      rif.soft_reset_1  = 1'b0;
      rif.soft_reset_2  = 1'b0;
      rif.parity_done   = 1'b0;
      rif.low_pkt_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      logic [10:0] got;
      logic [10:0] want;
      if (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         got  = {dbg_state, rif.busy, rif.detect_add, rif.lfd_state, rif.ld_state,
                 rif.laf_state, rif.full_state, rif.write_enb_reg, rif.rst_int_reg};
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL cycle%0d: got state=%0d outs=%b, want state=%0d outs=%b",
                     total, got[10:8], got[7:0], want[10:8], want[7:0]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: stimulus did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0;
      bad   = 0;
      idle();
      resetn = 1'b0;
      @(negedge clk);
      #1;
      // Reset held two cycles
      cyc(S_DEC);
      cyc(S_DEC);
      resetn = 1'b1;

      // Clean packet to port 1: LFD, LD x4, parity, check, decode
      rif.pkt_valid = 1'b1; rif.data_in = 2'd1; cyc(S_LFD);
      cyc(S_LD); cyc(S_LD); cyc(S_LD); cyc(S_LD);
      rif.pkt_valid = 1'b0; cyc(S_LP);
      cyc(S_CPE);
      cyc(S_DEC);

      // Busy destination: port 2 not empty for 5 cycles
      rif.pkt_valid = 1'b1; rif.data_in = 2'd2; rif.fifo_empty_2 = 1'b0; cyc(S_WAIT);
      cyc(S_WAIT); cyc(S_WAIT); cyc(S_WAIT); cyc(S_WAIT);
      rif.fifo_empty_2 = 1'b1; cyc(S_LFD);
      cyc(S_LD);
      rif.pkt_valid = 1'b0; cyc(S_LP);
      cyc(S_CPE);
      cyc(S_DEC);

      // Full stall for 3 cycles, resume, then full again on check, exit via parity_done
      rif.pkt_valid = 1'b1; rif.data_in = 2'd0; cyc(S_LFD);
      cyc(S_LD);
      rif.fifo_full = 1'b1; cyc(S_FULL);
      cyc(S_FULL); cyc(S_FULL);
      rif.fifo_full = 1'b0; cyc(S_LAF);
      cyc(S_LD);
      rif.pkt_valid = 1'b0; cyc(S_LP);
      rif.fifo_full = 1'b1; cyc(S_CPE);
      cyc(S_FULL);
      rif.fifo_full = 1'b0; cyc(S_LAF);
      rif.parity_done = 1'b1; cyc(S_DEC);
      idle();

      // Full with pkt_valid low together (full wins), then low_pkt_valid path
      rif.pkt_valid = 1'b1; rif.data_in = 2'd1; cyc(S_LFD);
      cyc(S_LD);
      rif.pkt_valid = 1'b0; rif.fifo_full = 1'b1; cyc(S_FULL);
      rif.fifo_full = 1'b0; cyc(S_LAF);
      rif.low_pkt_valid = 1'b1; cyc(S_LP);
      rif.low_pkt_valid = 1'b0; cyc(S_CPE);
      cyc(S_DEC);

      // Soft reset: other port ignored, selected port aborts
      rif.pkt_valid = 1'b1; rif.data_in = 2'd0; cyc(S_LFD);
      cyc(S_LD);
      rif.soft_reset_1 = 1'b1; cyc(S_LD);
      rif.soft_reset_1 = 1'b0; rif.soft_reset_0 = 1'b1; cyc(S_DEC);
      idle(); cyc(S_DEC);
      rif.pkt_valid = 1'b1; rif.data_in = 2'd2; rif.fifo_empty_2 = 1'b0; cyc(S_WAIT);
      rif.soft_reset_2 = 1'b1; cyc(S_DEC);
      idle();

      // Invalid address and idle decode
      rif.pkt_valid = 1'b1; rif.data_in = 2'd3; cyc(S_DEC);
      cyc(S_DEC);
      rif.pkt_valid = 1'b0; rif.data_in = 2'd1; cyc(S_DEC);

      // Reset mid-packet abandons it
      rif.pkt_valid = 1'b1; rif.data_in = 2'd1; cyc(S_LFD);
      cyc(S_LD);
      resetn = 1'b0; cyc(S_DEC);
      resetn = 1'b1; rif.pkt_valid = 1'b0; cyc(S_DEC);

      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
